// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main sequencing FSM for the multi-cycle MIPS datapath.
// Strobes are decoded from the registered state and mem_ready, and retired instructions are counted.
module mips_multicycle_control #(
  parameter int MIPS_OP_WIDTH = 6,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [MIPS_OP_WIDTH-1:0] opcode,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic                     mem_write,
  output logic                     i_or_d,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     pc_write_cond,
  output logic [1:0]               pc_src,
  output logic                     alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               alu_op,
  output logic                     reg_dst,
  output logic                     mem_to_reg,
  output logic                     reg_write,
  output logic                     illegal_op,
  output logic [CNT_WIDTH-1:0]     retired
);
  localparam logic [MIPS_OP_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [MIPS_OP_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [MIPS_OP_WIDTH-1:0] OP_SW    = 6'b101011;
  localparam logic [MIPS_OP_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [MIPS_OP_WIDTH-1:0] OP_ADDI  = 6'b001000;
  localparam logic [MIPS_OP_WIDTH-1:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    retire        = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        state_d    = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                     (opcode == OP_RTYPE) ? S_EXEC   :
                     (opcode == OP_BEQ)   ? S_BRANCH :
                     (opcode == OP_ADDI)  ? S_ADDIEX :
                     (opcode == OP_J)     ? S_JUMP   : S_FETCH;
        illegal_op = (state_d == S_FETCH);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
        state_d   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_RESET;
    endcase
    retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, retire};
  end

  assign retired = retired_q;
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multi-cycle, non-pipelined MIPS core. It sequences the shared datapath (PC, IR, register file, ALU, unified memory) through fetch, decode, execute, memory and writeback steps per instruction. It emits one-hot-style strobes and mux selects, and counts retired instructions. It waits on a memory ready handshake and flags unsupported opcodes.

Parameters:
MIPS_OP_WIDTH, 6, opcode field width, from the MIPS package
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26] from IR; valid from DECODE onward
mem_ready  in  1  memory completed the current request this cycle
mem_req  out  1  memory access requested (read or write)
mem_write  out  1  memory write
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
ir_write  out  1  load IR
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
alu_src_a  out  1  0=PC, 1=regA
alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  out  2  00=add, 01=sub, 10=decode funct
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  1  0=ALUOut, 1=MDR
reg_write  out  1  register file write
illegal_op  out  1  one-cycle pulse on unsupported opcode
retired  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Supported opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- States: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- All outputs are decoded from the registered state and mem_ready. No output depends on opcode except the DECODE transition.
- While rst_n=0: state=RESET, retired=0, all outputs 0. RESET drives all outputs 0 and moves to FETCH on the next clock. Reset mid-instruction aborts immediately; no partial writes are issued after assertion.
- Unlisted outputs are 0 in a state. mem_write and reg_write are never asserted outside MEMWR and MEMWB/ALUWB/ADDIWB respectively.
- FETCH:
  - Always drives mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=1 and pc_write=1 only in the cycle mem_ready=1, then go to DECODE; otherwise hold in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target).
  - LW/SW -> MEMADR; RTYPE -> EXEC; BEQ -> BRANCH; ADDI -> ADDIEX; J -> JUMP.
  - Any other opcode: illegal_op=1 this cycle, -> FETCH, retired not incremented.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_req=1, i_or_d=1. Hold until mem_ready=1, then -> MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEMWR: mem_req=1, mem_write=1, i_or_d=1. Hold, with strobes asserted, until mem_ready=1, then -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01 -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- JUMP: pc_write=1, pc_src=10 -> FETCH.
- Cycle counts with zero memory wait: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
- retired increments by 1 on the clock edge leaving MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^CNT_WIDTH.
- opcode is sampled only in DECODE and MEMADR; its changes elsewhere are ignored.

Test Plan:
- Reset then opcode=000000, mem_ready=1 constant -> states RESET,FETCH,DECODE,EXEC,ALUWB,FETCH; reg_write=1 with reg_dst=1 only in ALUWB; retired=1.
- LW (100011) with mem_ready low 2 cycles in FETCH and 3 in MEMRD -> ir_write/pc_write pulse exactly once; reg_write with mem_to_reg=1 once; total 10 cycles; retired=1.
- SW (101011), mem_ready=0 for 4 cycles in MEMWR -> mem_write=1, i_or_d=1 held 5 cycles; no reg_write; next state FETCH.
- BEQ then J back-to-back, mem_ready=1 -> pc_write_cond=1/pc_src=01 in BRANCH cycle 3; pc_write=1/pc_src=10 in JUMP cycle 6; retired=2.
- opcode=111111 -> illegal_op=1 for exactly the DECODE cycle; return to FETCH; retired unchanged; no write strobes.
- Assert rst_n=0 asynchronously mid-MEMWR with mem_write=1 -> mem_write/mem_req drop to 0 without a clock edge; retired=0; FETCH re-entered one cycle after release.
